// File: rtl/mem_dump_sender_pkg.sv
// Shared types and sizing helpers for the memory dump sender and its byte serializer.
package mem_dump_sender_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_FETCH,
    S_SEND,
    S_WAIT,
    S_NEXT,
    S_DRAIN
  } state_t;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int field_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_dump_sender_serializer.sv
// Loads one memory word and presents it one byte at a time, least significant byte first.
module word_byte_serializer
  import mem_dump_sender_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] word,
  output logic [7:0]        byte_lo,
  output logic              last
);

  localparam int BYTES = DATA_W / BYTE_W;
  localparam int IDX_W = field_width(BYTES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BYTES - 1);

  logic [DATA_W-1:0] shreg;
  logic [IDX_W-1:0]  idx;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
      idx   <= '0;
    end else if (load) begin
      shreg <= word;
      idx   <= '0;
    end else if (shift) begin
      shreg <= shreg >> BYTE_W;
      idx   <= idx + IDX_W'(1);
    end
  end

  assign byte_lo = shreg[7:0];
  assign last    = (idx == IDX_LAST);

endmodule

// File: rtl/mem_dump_sender.sv
// Streams an inclusive, wrapping address range of sample memory to a byte-wide UART TX core.
module mem_dump_sender
  import mem_dump_sender_pkg::*;
#(
  parameter int         ADDR_W      = 16,
  parameter int         DATA_W      = 8,
  parameter int         MEM_LATENCY = 1,
  parameter int         HEADER_EN   = 1,
  parameter logic [7:0] HEADER_BYTE = 8'hA5
) (
  input  logic              iClock,
  input  logic              iReset,
  input  logic              iStart,
  input  logic              iAbort,
  input  logic [ADDR_W-1:0] iStartAddr,
  input  logic [ADDR_W-1:0] iLastAddr,
  output logic [ADDR_W-1:0] oAddress,
  input  logic [DATA_W-1:0] iData,
  output logic [7:0]        oTxData,
  output logic              oTxSend,
  input  logic              iTxDone,
  output logic              oBusy,
  output logic              oDone
);

  localparam int LAT_W = field_width(MEM_LATENCY);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LATENCY - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] last_q, last_d, addr_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic              hdr_q, hdr_d;
  logic [7:0]        tx_data_d;
  logic              tx_send_d, busy_d, done_d;
  logic              ser_load, ser_shift, ser_last;
  logic [7:0]        ser_byte;

  word_byte_serializer #(.DATA_W(DATA_W)) u_ser (
    .clk    (iClock),
    .rst    (iReset),
    .load   (ser_load),
    .shift  (ser_shift),
    .word   (iData),
    .byte_lo(ser_byte),
    .last   (ser_last)
  );

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    addr_d    = oAddress;
    last_d    = last_q;
    lat_d     = lat_q;
    hdr_d     = hdr_q;
    tx_data_d = oTxData;
    tx_send_d = 1'b0;
    busy_d    = oBusy;
    done_d    = 1'b0;
    ser_load  = 1'b0;
    ser_shift = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (iStart && !iAbort) begin
          addr_d  = iStartAddr;
          last_d  = iLastAddr;
          lat_d   = '0;
          hdr_d   = (HEADER_EN != 0);
          busy_d  = 1'b1;
          state_d = (HEADER_EN != 0) ? S_HEADER : S_FETCH;
        end
      end
      S_HEADER: begin
        if (iAbort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          tx_data_d = HEADER_BYTE;
          tx_send_d = 1'b1;
          state_d   = S_WAIT;
        end
      end
      S_FETCH: begin
        if (iAbort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else if (lat_q == LAT_LAST) begin
          ser_load = 1'b1;
          state_d  = S_SEND;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      S_SEND: begin
        if (iAbort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          tx_data_d = ser_byte;
          tx_send_d = 1'b1;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        // A byte is in flight here, so a lone abort must still wait for the TX core.
        if (iTxDone) begin
          if (iAbort) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end else if (hdr_q) begin
            hdr_d   = 1'b0;
            lat_d   = '0;
            state_d = S_FETCH;
          end else if (!ser_last) begin
            ser_shift = 1'b1;
            state_d   = S_SEND;
          end else begin
            state_d = S_NEXT;
          end
        end else if (iAbort) begin
          state_d = S_DRAIN;
        end
      end
      S_NEXT: begin
        if (iAbort) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else if (oAddress == last_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          addr_d  = oAddress + ADDR_W'(1);
          lat_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_DRAIN: begin
        if (iTxDone) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q  <= S_IDLE;
      oAddress <= '0;
      last_q   <= '0;
      lat_q    <= '0;
      hdr_q    <= 1'b0;
      oTxData  <= '0;
      oTxSend  <= 1'b0;
      oBusy    <= 1'b0;
      oDone    <= 1'b0;
    end else begin
      state_q  <= state_d;
      oAddress <= addr_d;
      last_q   <= last_d;
      lat_q    <= lat_d;
      hdr_q    <= hdr_d;
      oTxData  <= tx_data_d;
      oTxSend  <= tx_send_d;
      oBusy    <= busy_d;
      oDone    <= done_d;
    end
  end

endmodule

// File: tb/tb_mem_dump_sender.sv
// Directed bench for mem_dump_sender: default 8-bit instance plus a 32-bit, no-header, latency-2 instance.
module tb_mem_dump_sender;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 8-bit default instance
  logic        start8, abort8, send8, txdone8, busy8, done_o8;
  logic [15:0] sa8, la8, addr8;
  logic [7:0]  data8, txdata8;

  // 32-bit, no header, latency 2 instance
  logic        start32, abort32, send32, txdone32, busy32, done_o32;
  logic [15:0] sa32, la32, addr32, addr32_q;
  logic [31:0] data32;
  logic [7:0]  txdata32;

  mem_dump_sender dut8 (
    .iClock(clk), .iReset(rst), .iStart(start8), .iAbort(abort8),
    .iStartAddr(sa8), .iLastAddr(la8), .oAddress(addr8), .iData(data8),
    .oTxData(txdata8), .oTxSend(send8), .iTxDone(txdone8),
    .oBusy(busy8), .oDone(done_o8)
  );

  mem_dump_sender #(.DATA_W(32), .HEADER_EN(0), .MEM_LATENCY(2)) dut32 (
    .iClock(clk), .iReset(rst), .iStart(start32), .iAbort(abort32),
    .iStartAddr(sa32), .iLastAddr(la32), .oAddress(addr32), .iData(data32),
    .oTxData(txdata32), .oTxSend(send32), .iTxDone(txdone32),
    .oBusy(busy32), .oDone(done_o32)
  );

  // Memory models: mem8[a] = a[7:0]; mem32[a] = {a[7:0]^44, 33, 22, 11}.
  assign data8 = addr8[7:0];
  always @(posedge clk) addr32_q <= addr32;
  assign data32 = {addr32_q[7:0] ^ 8'h44, 8'h33, 8'h22, 8'h11};

  // TX models: iTxDone pulses 10 cycles after a send; log bytes and handshake errors.
  logic [7:0] bytes8[$];
  logic [7:0] bytes32[$];
  logic [7:0] inflight8;
  int cnt8 = 0, cnt32 = 0, done_cnt8 = 0, done_cnt32 = 0, stab_err = 0, overlap_err = 0;

  always @(posedge clk) begin
    if (rst) begin
      cnt8    <= 0;
      txdone8 <= 1'b0;
    end else begin
      txdone8 <= 1'b0;
      if (send8) begin
        if (cnt8 != 0) overlap_err <= overlap_err + 1;
        cnt8      <= 10;
        inflight8 <= txdata8;
        bytes8.push_back(txdata8);
      end else if (cnt8 != 0) begin
        if (txdata8 != inflight8) stab_err <= stab_err + 1;
        cnt8 <= cnt8 - 1;
        if (cnt8 == 1) txdone8 <= 1'b1;
      end
      if (done_o8) done_cnt8 <= done_cnt8 + 1;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      cnt32    <= 0;
      txdone32 <= 1'b0;
    end else begin
      txdone32 <= 1'b0;
      if (send32) begin
        cnt32 <= 10;
        bytes32.push_back(txdata32);
      end else if (cnt32 != 0) begin
        cnt32 <= cnt32 - 1;
        if (cnt32 == 1) txdone32 <= 1'b1;
      end
      if (done_o32) done_cnt32 <= done_cnt32 + 1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_done8(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done_o8) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_txdone8(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (txdone8) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_bytes8(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (bytes8.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  typedef struct {
    logic [15:0]     start;
    logic [15:0]     last;
    int              n;
    logic [7:0][7:0] bytes;   // byte 0 in the low lane
  } vec_t;

  task automatic run_dump8(input string tag, input vec_t v);
    int base, dbase;
    bit ok;
    base  = bytes8.size();
    dbase = done_cnt8;
    @(negedge clk);
    start8 = 1'b1; sa8 = v.start; la8 = v.last;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    check({tag, "_busy_rise"}, 32'(busy8), 32'd1);
    check({tag, "_send_n1"}, 32'(send8), 32'd0);
    @(negedge clk);
    check({tag, "_send_n2"}, 32'(send8), 32'd1);
    wait_done8(ok);
    check({tag, "_done_seen"}, 32'(ok), 32'd1);
    check({tag, "_busy_at_done"}, 32'(busy8), 32'd0);
    check({tag, "_addr_end"}, 32'(addr8), 32'(v.last));
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done_o8), 32'd0);
    check({tag, "_nbytes"}, 32'(bytes8.size() - base), 32'(v.n));
    for (int i = 0; i < v.n; i++)
      check($sformatf("%s_byte%0d", tag, i),
            (base + i < bytes8.size()) ? 32'(bytes8[base + i]) : 32'hDEAD,
            32'(v.bytes[i]));
    check({tag, "_ndone"}, 32'(done_cnt8 - dbase), 32'd1);
  endtask

  initial begin
    vec_t vecs[4];
    vec_t v;
    int   base, dbase;
    bit   ok;
    logic [7:0] exp32[8];

    vecs[0] = '{16'h0010, 16'h0012, 4, 64'h00000000_121110A5};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 2, 64'h00000000_0000FFA5};
    vecs[2] = '{16'hFFFE, 16'h0001, 5, 64'h00000001_00FFFEA5};
    vecs[3] = '{16'h0080, 16'h0080, 2, 64'h00000000_000080A5};
    exp32   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11, 8'h22, 8'h33, 8'h45};

    rst = 1'b1;
    start8 = 1'b0; abort8 = 1'b0; sa8 = '0; la8 = '0;
    start32 = 1'b0; abort32 = 1'b0; sa32 = '0; la32 = '0;
    repeat (3) @(negedge clk);
    check("rst_addr", 32'(addr8), 32'd0);
    check("rst_txdata", 32'(txdata8), 32'd0);
    check("rst_send", 32'(send8), 32'd0);
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_done", 32'(done_o8), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int k = 0; k < 4; k++) run_dump8($sformatf("vec%0d", k), vecs[k]);

    // 32-bit words, LSB byte first, no header, latency 2
    base  = bytes32.size();
    dbase = done_cnt32;
    @(negedge clk);
    start32 = 1'b1; sa32 = 16'h0000; la32 = 16'h0001;
    @(posedge clk);
    @(negedge clk);
    start32 = 1'b0;
    check("w32_busy_rise", 32'(busy32), 32'd1);
    check("w32_send_j0", 32'(send32), 32'd0);
    @(negedge clk);
    check("w32_send_j1", 32'(send32), 32'd0);
    @(negedge clk);
    check("w32_send_j2", 32'(send32), 32'd0);
    @(negedge clk);
    check("w32_send_j3", 32'(send32), 32'd1);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done_o32) begin ok = 1'b1; break; end
    end
    check("w32_done_seen", 32'(ok), 32'd1);
    check("w32_nbytes", 32'(bytes32.size() - base), 32'd8);
    for (int i = 0; i < 8; i++)
      check($sformatf("w32_byte%0d", i),
            (base + i < bytes32.size()) ? 32'(bytes32[base + i]) : 32'hDEAD, 32'(exp32[i]));
    @(negedge clk);
    check("w32_ndone", 32'(done_cnt32 - dbase), 32'd1);

    // Abort during WAIT of the second byte; a mid-dump iStart is ignored
    base  = bytes8.size();
    dbase = done_cnt8;
    @(negedge clk);
    start8 = 1'b1; sa8 = 16'h0020; la8 = 16'h0025;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    start8 = 1'b1; sa8 = 16'h0050; la8 = 16'h0050;
    @(negedge clk);
    start8 = 1'b0;
    wait_bytes8(base + 2, ok);
    check("abort_reach_b2", 32'(ok), 32'd1);
    abort8 = 1'b1;
    wait_txdone8(ok);
    check("abort_txdone_seen", 32'(ok), 32'd1);
    check("abort_busy_drain", 32'(busy8), 32'd1);
    @(negedge clk);
    check("abort_busy_idle", 32'(busy8), 32'd0);
    abort8 = 1'b0;
    repeat (30) @(negedge clk);
    check("abort_nbytes", 32'(bytes8.size() - base), 32'd2);
    check("abort_byte1", (base + 1 < bytes8.size()) ? 32'(bytes8[base + 1]) : 32'hDEAD, 32'h20);
    check("abort_ndone", 32'(done_cnt8 - dbase), 32'd0);

    // Abort coincident with iTxDone in WAIT goes straight to IDLE
    base = bytes8.size();
    @(negedge clk);
    start8 = 1'b1; sa8 = 16'h0060; la8 = 16'h0062;
    @(negedge clk);
    start8 = 1'b0;
    wait_bytes8(base + 2, ok);
    check("abtx_reach_b2", 32'(ok), 32'd1);
    wait_txdone8(ok);
    check("abtx_txdone_seen", 32'(ok), 32'd1);
    abort8 = 1'b1;
    @(negedge clk);
    abort8 = 1'b0;
    check("abtx_busy_idle", 32'(busy8), 32'd0);
    repeat (30) @(negedge clk);
    check("abtx_nbytes", 32'(bytes8.size() - base), 32'd2);
    check("abtx_ndone", 32'(done_cnt8 - dbase), 32'd0);

    // iStart together with iAbort in IDLE: stay idle
    base = bytes8.size();
    @(negedge clk);
    start8 = 1'b1; abort8 = 1'b1; sa8 = 16'h0070; la8 = 16'h0070;
    @(negedge clk);
    start8 = 1'b0; abort8 = 1'b0;
    check("startabort_busy", 32'(busy8), 32'd0);
    repeat (5) @(negedge clk);
    check("startabort_nbytes", 32'(bytes8.size() - base), 32'd0);

    // Reset while in SEND, then a fresh dump completes
    base = bytes8.size();
    @(negedge clk);
    start8 = 1'b1; sa8 = 16'h0030; la8 = 16'h0033;
    @(negedge clk);
    start8 = 1'b0;
    wait_bytes8(base + 2, ok);
    check("rstsend_reach_b2", 32'(ok), 32'd1);
    wait_txdone8(ok);
    check("rstsend_txdone_seen", 32'(ok), 32'd1);
    repeat (3) @(negedge clk);   // WAIT -> NEXT -> FETCH -> SEND
    check("rstsend_busy_pre", 32'(busy8), 32'd1);
    check("rstsend_send_pre", 32'(send8), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rstsend_addr", 32'(addr8), 32'd0);
    check("rstsend_txdata", 32'(txdata8), 32'd0);
    check("rstsend_send", 32'(send8), 32'd0);
    check("rstsend_busy", 32'(busy8), 32'd0);
    check("rstsend_done", 32'(done_o8), 32'd0);
    check("rstsend_nbytes", 32'(bytes8.size() - base), 32'd2);
    rst = 1'b0;
    @(negedge clk);
    v = '{16'h0040, 16'h0041, 3, 64'h00000000_004140A5};
    run_dump8("after_rst", v);

    check("tx_data_stable", 32'(stab_err), 32'd0);
    check("tx_no_overlap", 32'(overlap_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
